arb_mux_n: RTL and testbench
============================

# arb_mux_n

- Parametrised, registered N-channel arbitrating multiplexer.
- Selects one of NCH valid/ready input channels of WIDTH bits and drives a single registered valid/ready output.
- Supports round-robin or fixed-priority arbitration.
- Sits between multiple bus masters (instruction fetch, data access, DMA/peripheral) and the shared memory/peripheral port of the SoC, replacing hard-wired 2:1 data-path selection where sources contend.

## Interface
Parameters:
- WIDTH, 32, data width of every channel and of the output
- NCH, 4, number of input channels, legal range 2..8
- SELW, 2, width of the channel index; must equal ceil(log2(NCH)), minimum 1

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = round-robin, 1 = fixed priority (channel 0 highest)
- in_valid  input  NCH  per-channel request/valid
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  NCH  per-channel accept, combinational
- out_valid  output  1  output register holds a word
- out_ready  input  1  downstream accepts the output word
- out_data  output  WIDTH  registered selected word
- out_sel  output  SELW  index of the channel that supplied out_data

## Operation
- One-entry output register: out_valid, out_data, out_sel, plus round-robin pointer rr_ptr (SELW bits).
- Reset values: out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready is 0 while rst is high.
- can_accept = !out_valid | out_ready.
- The arbiter computes a one-hot grant over in_valid each cycle:
  - mode=1: lowest-index valid channel wins.
  - mode=0: first valid channel searching rr_ptr, rr_ptr+1, ..., wrapping modulo NCH.
- in_ready[i] = grant[i] & can_accept. At most one in_ready bit is high. in_ready may depend on in_valid, but in_valid must not depend on in_ready.
- Transfer on channel i when in_valid[i] & in_ready[i]:
  - Next edge: out_data <= in_data[i], out_sel <= i, out_valid <= 1.
  - rr_ptr <= (i+1) mod NCH. Wrap from NCH-1 to 0. rr_ptr updates in both modes.
- Output drained (out_valid & out_ready) with no new transfer: out_valid <= 0; out_data and out_sel hold their last value.
- Simultaneous drain and transfer: the register reloads, out_valid stays 1, and there is no bubble.
- out_valid & !out_ready: out_data and out_sel are held stable, and all in_ready bits are 0.
- No valid inputs: grant is all zero, and rr_ptr and the output register are unchanged.
- mode may change on any cycle and takes effect on that cycle's arbitration. rr_ptr is not reset by a mode change.
- rst asserted mid-transfer: the pending output word is discarded. The input handshake in that cycle is not a transfer.

## Timing
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word/cycle while out_ready is held high and any input is valid.
- Critical path: in_valid -> arbiter -> in_ready; out_ready -> in_ready. No register on the ready path.
- Fairness: in mode=0 a continuously valid channel is granted within NCH transfers.

## Configuration
- ARB_MUX_LOCK_EN defined:
  - Adds port lock (input, 1).
  - When a transfer on channel i occurs with lock=1, the grant is pinned to i on following cycles while lock stays 1, regardless of mode, even if other channels are valid.
  - If in_valid[i] is 0 while locked, no channel is granted.
  - Lock releases on the first cycle lock=0. Arbitration then resumes from rr_ptr (mode 0) or by priority (mode 1).
  - Lock state resets to unlocked.
- ARB_MUX_LOCK_EN undefined: no lock port, no lock state, and arbitration is purely as above.

## Test plan
- Reset: assert rst 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0. The first grant after release is channel 0.
- Round-robin: mode=0, NCH=4, all channels valid with data 0xA0..0xA3, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles with matching out_data, and no bubbles.
- Fixed priority: mode=1, in_valid=4'b1010 -> channel 1 granted every cycle. Drop in_valid[1] -> channel 3 granted next cycle.
- Backpressure: out_ready=0 after a word 0xDEADBEEF from channel 2 -> out_data/out_sel held for 5 cycles, in_ready=0. Raise out_ready -> the next word is loaded in the same edge with no gap.
- Wrap and sparse: mode=0, rr_ptr=3, only in_valid[1]=1 -> channel 1 granted, rr_ptr becomes 2.
- With ARB_MUX_LOCK_EN: lock=1 on a transfer from channel 2 with all channels valid -> 4 consecutive transfers from channel 2. Deassert lock -> next grant is channel 3.

Source files
------------

// File: rtl/arb_mux_n.sv
// arb_mux_n: registered N-channel valid/ready arbitrating mux, round-robin or fixed priority; ARB_MUX_LOCK_EN adds a grant-lock input
module arb_mux_n #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
`ifdef ARB_MUX_LOCK_EN
  input  logic                 lock,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel
);
  logic             valid_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [SELW-1:0]  rr_q, rr_d;
  logic [NCH-1:0]   hi, grant;
  logic             any, can_accept, xfer;
`ifdef ARB_MUX_LOCK_EN
  logic             lock_q;
  logic [SELW-1:0]  lsel_q;
`endif

  function automatic logic [SELW-1:0] first(input logic [NCH-1:0] v);
    first = '0;
    for (int i = NCH-1; i >= 0; i--) if (v[i]) first = SELW'(i);
  endfunction

  assign can_accept = !valid_q | out_ready;
  assign in_ready   = rst ? '0 : grant & {NCH{can_accept}};
  assign xfer       = |in_ready;
  assign rr_d       = (sel_d == SELW'(NCH-1)) ? '0 : sel_d + 1'b1;
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_sel    = sel_q;

  // Winner: lowest valid at or above rr_ptr else lowest valid (mode 0), lowest valid (mode 1), or the locked channel
  always_comb begin
    hi    = in_valid & ~((NCH'(1) << rr_q) - NCH'(1));
    sel_d = first(mode ? in_valid : (|hi ? hi : in_valid));
    any   = |in_valid;
`ifdef ARB_MUX_LOCK_EN
    if (lock_q && lock) begin
      sel_d = lsel_q;
      any   = in_valid[lsel_q];
    end
`endif
    grant = any ? NCH'(1) << sel_d : '0;
  end

  // Select the granted channel's word
  always_comb begin
    data_d = '0;
    for (int i = 0; i < NCH; i++) if (sel_d == SELW'(i)) data_d = in_data[i*WIDTH +: WIDTH];
  end

  // One-entry output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      rr_q    <= '0;
    end else if (xfer) begin
      valid_q <= 1'b1;
      data_q  <= data_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef ARB_MUX_LOCK_EN
  // Lock pins the grant to the channel that transferred while lock was high
  always_ff @(posedge clk) begin
    if (rst || !lock) begin
      lock_q <= 1'b0;
      lsel_q <= '0;
    end else if (xfer) begin
      lock_q <= 1'b1;
      lsel_q <= sel_d;
    end
  end
`endif
endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: directed self-checking bench for arb_mux_n (NCH=4, WIDTH=32)
module tb_arb_mux_n;
  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
`ifdef ARB_MUX_LOCK_EN
  logic         lock = 1'b0;
`endif
  int           n_chk = 0;
  int           n_fail = 0;

  arb_mux_n #(.WIDTH(32), .NCH(4), .SELW(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready),
`ifdef ARB_MUX_LOCK_EN
    .lock(lock),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic out_is(input string tag, input logic v, input logic [1:0] s, input logic [31:0] d);
    check({tag, " valid"}, 32'(out_valid), 32'(v));
    check({tag, " sel"}, 32'(out_sel), 32'(s));
    check({tag, " data"}, out_data, d);
  endtask

  task automatic rdy_is(input string tag, input logic [3:0] r);
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'(r));
  endtask

  initial begin
    logic [1:0] rr_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1; mode = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    tick(); tick();
    out_is("reset", 1'b0, 2'd0, 32'h0);
    rdy_is("reset", 4'b0000);
    rst = 1'b0;
    rdy_is("first grant", 4'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      out_is($sformatf("rr%0d", i), 1'b1, rr_seq[i], 32'hA0 + 32'(rr_seq[i]));
    end
    mode = 1'b1; in_valid = 4'b1010;
    rdy_is("prio", 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      out_is($sformatf("prio%0d", i), 1'b1, 2'd1, 32'hA1);
    end
    in_valid = 4'b1000;
    tick();
    out_is("prio drop", 1'b1, 2'd3, 32'hA3);
    in_valid = 4'b0100; in_data[64 +: 32] = 32'hDEADBEEF;
    tick();
    out_is("bp load", 1'b1, 2'd2, 32'hDEADBEEF);
    out_ready = 1'b0; in_valid = 4'hF; in_data[64 +: 32] = 32'hA2;
    for (int i = 0; i < 5; i++) begin
      rdy_is($sformatf("bp%0d", i), 4'b0000);
      tick();
      out_is($sformatf("bp%0d", i), 1'b1, 2'd2, 32'hDEADBEEF);
    end
    out_ready = 1'b1;
    rdy_is("bp release", 4'b0001);
    tick();
    out_is("bp release", 1'b1, 2'd0, 32'hA0);
    in_valid = 4'b0000;
    rdy_is("idle", 4'b0000);
    tick();
    out_is("drain", 1'b0, 2'd0, 32'hA0);
    tick();
    out_is("idle hold", 1'b0, 2'd0, 32'hA0);
    mode = 1'b0; in_valid = 4'hF;
    rdy_is("rr ptr held", 4'b0010);
    mode = 1'b1; in_valid = 4'b0100;
    tick();
    out_is("to rr3", 1'b1, 2'd2, 32'hA2);
    mode = 1'b0; in_valid = 4'b0010;
    rdy_is("sparse", 4'b0010);
    tick();
    out_is("sparse", 1'b1, 2'd1, 32'hA1);
    in_valid = 4'hF;
    rdy_is("rr after sparse", 4'b0100);
    in_valid = 4'b1011;
    rdy_is("rr wrap skip", 4'b1000);
    tick();
    out_is("rr wrap skip", 1'b1, 2'd3, 32'hA3);
    in_valid = 4'hF;
    rdy_is("before rst", 4'b0001);
    rst = 1'b1;
    rdy_is("mid rst", 4'b0000);
    tick();
    out_is("mid rst", 1'b0, 2'd0, 32'h0);
    rst = 1'b0; in_valid = 4'b0100;
    rdy_is("after rst", 4'b0100);
    in_valid = 4'hF;
    rdy_is("after rst rr0", 4'b0001);
`ifdef ARB_MUX_LOCK_EN
    in_valid = 4'b0010;
    tick();
    out_is("lock pre", 1'b1, 2'd1, 32'hA1);
    in_valid = 4'hF; lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rdy_is($sformatf("lock%0d", i), 4'b0100);
      tick();
      out_is($sformatf("lock%0d", i), 1'b1, 2'd2, 32'hA2);
    end
    in_valid = 4'b1011;
    rdy_is("lock starve", 4'b0000);
    tick();
    out_is("lock starve", 1'b0, 2'd2, 32'hA2);
    in_valid = 4'hF; lock = 1'b0;
    rdy_is("unlock", 4'b1000);
    tick();
    out_is("unlock", 1'b1, 2'd3, 32'hA3);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
